// File: rtl/lz_expand.sv
// rtl/lz_expand.sv - leading-zero expander: {zero, count, mantissa} beats to full words, 2-stage pipe.
// Optional LZ_EXPAND_ROUND_EN sets a mid-point bit just below the mantissa.
module lz_expand #(
  parameter int W_WORD  = 8,
  parameter int W_CNT   = $clog2(W_WORD),
  parameter int M_BITS  = 3,
  parameter int W_BEATS = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic                                 in_zero,
  input  logic [W_CNT-1:0]                     in_count,
  input  logic [((M_BITS > 0) ? M_BITS : 1)-1:0] in_mant,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [W_WORD-1:0]                    out_data,
  output logic [W_BEATS-1:0]                   out_beats
);

  localparam int W_MP    = (M_BITS > 0) ? M_BITS : 1;
  localparam int RND_POS = W_WORD - 2 - M_BITS;
  localparam int RND_SH  = (RND_POS >= 0) ? RND_POS : 0;
  localparam logic [W_WORD-1:0] ONE_W    = {{(W_WORD-1){1'b0}}, 1'b1};
  localparam logic [W_WORD-1:0] RND_MASK = (RND_POS >= 0) ? (ONE_W << RND_SH) : '0;

  logic              s1_valid_q, s1_valid_d;
  logic              s1_zero_q,  s1_zero_d;
  logic [W_CNT-1:0]  s1_count_q, s1_count_d;
  logic [W_MP-1:0]   s1_mant_q,  s1_mant_d;
  logic              out_valid_q, out_valid_d;
  logic [W_WORD-1:0] out_data_q,  out_data_d;
  logic [W_BEATS-1:0] beats_q,    beats_d;

  logic              s2_take;
  logic              s1_take;
  logic [W_WORD-1:0] base_w;
  logic [W_WORD-1:0] expanded;

  assign s2_take  = !out_valid_q || out_ready;
  assign s1_take  = !s1_valid_q || s2_take;
  assign in_ready = s1_take;

  // Leading one at the MSB with the mantissa directly below; the shift drops what falls off bit 0.
  always_comb begin
    base_w = '0;
    base_w[W_WORD-1] = 1'b1;
    for (int i = 0; i < M_BITS; i++) begin
      base_w[W_WORD-2-i] = s1_mant_q[M_BITS-1-i];
    end
`ifdef LZ_EXPAND_ROUND_EN
    base_w = base_w | RND_MASK;
`endif
    expanded = s1_zero_q ? '0 : (base_w >> s1_count_q);
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_zero_d   = s1_zero_q;
    s1_count_d  = s1_count_q;
    s1_mant_d   = s1_mant_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    beats_d     = beats_q;

    if (s1_take) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_zero_d  = in_zero;
        s1_count_d = in_count;
        s1_mant_d  = in_mant;
      end
    end

    if (s2_take) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = expanded;
      end
    end

    if (out_valid_q && out_ready) begin
      beats_d = beats_q + W_BEATS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_count_q  <= '0;
      s1_mant_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      beats_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_zero_q   <= s1_zero_d;
      s1_count_q  <= s1_count_d;
      s1_mant_q   <= s1_mant_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      beats_q     <= beats_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_beats = beats_q;

endmodule

// File: tb/tb_lz_expand.sv
// tb/tb_lz_expand.sv - table-driven scoreboard bench for lz_expand (W_WORD=8, M_BITS=3, W_BEATS=4).
module tb_lz_expand;

  typedef struct {
    logic       zero;
    logic [2:0] cnt;
    logic [2:0] mant;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0] exp;
    int         acc;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_zero = 1'b0;
  logic [2:0] in_count = '0;
  logic [2:0] in_mant = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic [3:0] out_beats;

  lz_expand #(.W_WORD(8), .M_BITS(3), .W_BEATS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_zero(in_zero), .in_count(in_count), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_beats(out_beats)
  );

  always #5 clk = ~clk;

  vec_t       tab[8];
  vec_t       idle;
  sb_t        q[$];
  int         cyc = 0;
  int         n_vec = 0;
  int         n_bad = 0;
  logic [3:0] beats_exp = '0;
  bit         lat_chk = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic cycle(input bit v, input vec_t t, input bit ordy, output bit acc);
    sb_t e;
    @(negedge clk);
    in_valid  = v;
    in_zero   = t.zero;
    in_count  = t.cnt;
    in_mant   = t.mant;
    out_ready = ordy;
    #2;
    acc = v && in_ready;
    if (acc) begin
      e.exp = t.exp;
      e.acc = cyc;
      q.push_back(e);
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("out_data", 32'(out_data), 32'(e.exp));
        if (lat_chk) check("latency", 32'(cyc - e.acc), 32'd2);
      end
      beats_exp++;
    end
    @(posedge clk);
    #1;
    cyc++;
    check("out_beats", 32'(out_beats), 32'(beats_exp));
  endtask

  task automatic drain();
    bit a;
    for (int i = 0; i < 20 && q.size() > 0; i++) cycle(1'b0, idle, 1'b1, a);
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_beats", 32'(out_beats), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    beats_exp = '0;
    #1;
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic z, input logic [2:0] c, input logic [2:0] m,
                              input logic [7:0] e_plain, input logic [7:0] e_rnd);
    vec_t v;
    v.zero = z; v.cnt = c; v.mant = m;
`ifdef LZ_EXPAND_ROUND_EN
    v.exp = e_rnd;
`else
    v.exp = e_plain;
`endif
    return v;
  endfunction

  initial begin
    bit         a;
    int         idx;
    bit         got_ref;
    logic [7:0] ref_d;
    logic [7:0] b2b_plain;
    logic [7:0] b2b_rnd;

    tab[0] = mk(1'b0, 3'd2, 3'b101, 8'h34, 8'h36);
    tab[1] = mk(1'b0, 3'd7, 3'b111, 8'h01, 8'h01);
    tab[2] = mk(1'b0, 3'd0, 3'b000, 8'h80, 8'h88);
    tab[3] = mk(1'b1, 3'd5, 3'b110, 8'h00, 8'h00);
    tab[4] = mk(1'b0, 3'd1, 3'b111, 8'h78, 8'h7C);
    tab[5] = mk(1'b0, 3'd3, 3'b010, 8'h14, 8'h15);
    tab[6] = mk(1'b0, 3'd6, 3'b100, 8'h03, 8'h03);
    tab[7] = mk(1'b0, 3'd4, 3'b011, 8'h0B, 8'h0B);
    idle = mk(1'b0, 3'd0, 3'd0, 8'h00, 8'h00);

    #2;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_out_beats", 32'(out_beats), 32'd0);
    #1;
    rst_n = 1'b1;

    // table vectors, out_ready high, two-edge latency
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, tab[i], 1'b1, a);
      check("table_accept", 32'(a), 32'd1);
    end
    drain();

    // back-to-back count 0..7, mant 0
    do_reset();
    for (int c = 0; c < 8; c++) begin
      b2b_plain = 8'h80 >> c;
      b2b_rnd   = 8'h88 >> c;
      cycle(1'b1, mk(1'b0, 3'(c), 3'b000, b2b_plain, b2b_rnd), 1'b1, a);
      check("b2b_accept", 32'(a), 32'd1);
    end
    drain();
    check("b2b_beats", 32'(out_beats), 32'd8);

    // stall: 5 cycles of out_ready=0 with input offered
    lat_chk = 1'b0;
    idx = 0;
    got_ref = 1'b0;
    ref_d = '0;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, tab[idx], 1'b0, a);
      if (a) idx++;
      if (out_valid) begin
        if (got_ref) check("stall_hold", 32'(out_data), 32'(ref_d));
        else begin
          ref_d = out_data;
          got_ref = 1'b1;
        end
      end
    end
    check("stall_accepts", 32'(idx), 32'd2);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    for (int k = 0; k < 20 && idx < 5; k++) begin
      cycle(1'b1, tab[idx], 1'b1, a);
      if (a) idx++;
    end
    check("stall_release_accepts", 32'(idx), 32'd5);
    drain();

    // random valid / ready mix
    for (int k = 0; k < 60; k++) begin
      cycle(1'($urandom_range(0, 1)), tab[$urandom_range(0, 7)], 1'($urandom_range(0, 1)), a);
    end
    drain();

    // reset with both stages full
    cycle(1'b1, tab[0], 1'b0, a);
    cycle(1'b1, tab[1], 1'b0, a);
    check("full_before_rst", 32'(out_valid), 32'd1);
    do_reset();
    lat_chk = 1'b1;
    cycle(1'b1, tab[5], 1'b1, a);
    check("post_rst_accept", 32'(a), 32'd1);
    drain();

    // beat counter wrap with W_BEATS=4
    do_reset();
    for (int k = 0; k < 17; k++) cycle(1'b1, tab[k % 8], 1'b1, a);
    drain();
    check("wrap_beats", 32'(out_beats), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish within bound");
    $fatal(1);
  end

endmodule

// File: doc/lz_expand.md
# lz_expand

Streaming leading-zero expander: the decode side of the count-leading-zero compressor. Each accepted input beat carries a leading-zero count, a truncated mantissa (the bits directly below the leading one) and a zero flag. The block rebuilds the full-width word and emits it through a two-stage valid/ready pipeline with full backpressure. It sits on the receive path, after the link that carries {zero, count, mantissa} tuples produced by the compressor.

## Interface
- `W_WORD`, 8: reconstructed word width; power of 2, >=2.
- `W_CNT`, `$clog2(W_WORD)`: count width; leave at default.
- `M_BITS`, 3: mantissa bits carried per beat; 0 <= M_BITS <= W_WORD-1.
- `W_BEATS`, 16: width of the output beat counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: input beat accepted when `in_valid && in_ready`.
- `in_zero` in 1: original word was all zeros; count and mantissa are ignored.
- `in_count` in W_CNT: leading-zero count, 0..W_WORD-1.
- `in_mant` in M_BITS: bits below the leading one, MSB first (absent when M_BITS=0).
- `out_valid` out 1: output word valid.
- `out_ready` in 1: downstream accepts when `out_valid && out_ready`.
- `out_data` out W_WORD: reconstructed word.
- `out_beats` out W_BEATS: count of completed output handshakes; wraps.

## Operation
- Reconstruction: `out_data = {1'b1, in_mant, (W_WORD-1-M_BITS)'b0} >> in_count`, truncated to W_WORD bits.
  - The leading one lands at bit W_WORD-1-in_count.
  - Mantissa bits shifted below bit 0 are dropped.
  - `in_zero=1` forces `out_data=0`.
- Stage 1 (S1) registers the zero flag, count and mantissa, plus `s1_valid`.
- Stage 2 (S2) computes the shift from S1 and registers `out_data` and `out_valid`.
- Accept rules:
  - `s2_take = !out_valid || out_ready`.
  - `s1_take = !s1_valid || s2_take`.
  - `in_ready = s1_take`. This is combinational from `out_ready`. No skid buffer.
- Beat counter: `out_beats` increments by 1 on every output handshake. It wraps from 2^W_BEATS-1 to 0.
- Out-of-range count: values >= W_WORD are not possible for power-of-2 W_WORD, so no check is needed.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_beats=0`, `s1_valid=0`, so `in_ready=1` during and after reset.
- Latency: an input accepted at edge N appears on `out_data`/`out_valid` after edge N+1 (2 register stages), provided `out_ready` stays high.
- Throughput: 1 beat/cycle with `out_ready` held high.
- Backpressure:
  - While `out_valid && !out_ready`: `out_data` holds stable.
  - S1 holds if valid, and `in_ready` is 0 when S1 is occupied.
  - Maximum of 2 beats in flight.
- Simultaneous events: with a full pipe and `out_ready=1`, an input accepted in the same cycle enters S1 while S1 moves to S2. No bubble.
- Mid-operation reset: all in-flight beats are discarded and outputs return to their reset values immediately (asynchronous). Input is accepted on the first edge after deassertion.
- `out_valid` must not drop without a handshake.

## Configuration
- `LZ_EXPAND_ROUND_EN`
  - Defined: a mid-point reconstruction bit is set at position W_WORD-2-M_BITS-in_count when that position is >= 0. This halves the worst-case truncation error. It is not applied when `in_zero=1`.
  - Undefined: bits below the mantissa are zero-filled. Pipeline timing is identical either way.

## Test plan
- W_WORD=8, M_BITS=3, input (zero=0, count=2, mant=3'b101), `out_ready=1`:
  - `out_data=8'h34` two edges after acceptance.
  - With `LZ_EXPAND_ROUND_EN`: 8'h36.
- Edge values:
  - count=7, mant=3'b111 -> 8'h01 (mantissa fully dropped; no rounding bit).
  - count=0, mant=3'b000 -> 8'h80 (8'h88 with rounding).
  - zero=1, count=5 -> 8'h00 in both builds.
- Back-to-back stream of 8 beats, count=0..7, mant=0, `out_ready=1`:
  - Outputs 8'h80, 8'h40, ..., 8'h01 on consecutive cycles.
  - `out_beats=8`.
- Stall: hold `out_ready=0` for 5 cycles while driving `in_valid=1`:
  - Exactly 2 beats accepted, then `in_ready=0`.
  - `out_data` stable throughout.
  - On release, beats emerge in order with no loss or duplication.
- Assert `rst_n=0` mid-stream with both stages full:
  - `out_valid` and `out_beats` clear immediately; `in_ready=1`.
  - The first post-reset beat emerges with 2-edge latency.
- Wrap: W_BEATS=4, 17 handshakes -> `out_beats=1`.
